// File: rtl/fifo_drain_arbiter_if.sv
// Bus bundle for fifo_drain_arbiter: the per-channel FIFO read side and the drained output stream.
// master = the arbiter, slave = the FIFOs plus the downstream consumer.
interface fifo_drain_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]        ch_empty;
   logic [NUM_CH-1:0]        ch_rdreq;
   logic [NUM_CH*DATA_W-1:0] ch_q;
   logic [DATA_W-1:0]        out_data;
   logic [CH_W-1:0]          out_channel;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      input  ch_empty, ch_q, out_ready,
      output ch_rdreq, out_data, out_channel, out_valid
   );

   modport slave (
      output ch_empty, ch_q, out_ready,
      input  ch_rdreq, out_data, out_channel, out_valid
   );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drainer of NUM_CH non-showahead FIFOs into one ready/valid stream via a 2-entry skid buffer.
// Optional macro FIFO_DRAIN_STATS_EN enables the saturating word_count of output transfers.
module fifo_drain_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   fifo_drain_arbiter_if.master bus,
   output logic                 busy,
   output logic [15:0]          word_count
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, BURST} state_e;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic              infl_q, infl_d;
   logic [CH_W-1:0]   infl_ch_q, infl_ch_d;
   logic [1:0]        occ_q, occ_d;
   logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [CH_W-1:0]   head_ch_q, head_ch_d, tail_ch_q, tail_ch_d;

   logic              any_req;
   logic [CH_W-1:0]   pick;
   logic [CH_W-1:0]   idx;
   logic              rdreq_en;
   logic              burst_done;
   logic              credit;
   logic              push;
   logic              pop;
   logic [2:0]        pending;
   logic [DATA_W-1:0] word_in;

   // First non-empty channel at or above rr_ptr, with wrap; lowest offset wins.
   always_comb begin
      any_req = 1'b0;
      pick    = rr_ptr_q;
      idx     = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
         if (!bus.ch_empty[idx]) begin
            any_req = 1'b1;
            pick    = idx;
         end
      end
   end

   // Reads already issued plus buffered words must leave room for the next one.
   assign pop     = (occ_q != 2'd0) && bus.out_ready;
   assign push    = infl_q;
   assign pending = 3'(occ_q) + 3'(infl_q) - 3'(pop);
   assign credit  = (pending < 3'd2);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      rd_cnt_d = rd_cnt_q;
      case (state_q)
         IDLE: begin
            if (enable && any_req) begin
               state_d  = BURST;
               grant_d  = pick;
               rr_ptr_d = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + CH_W'(1);
               rd_cnt_d = '0;
            end
         end
         BURST: begin
            if (rdreq_en) rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (burst_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdreq_en     = 1'b0;
      burst_done   = 1'b0;
      bus.ch_rdreq = '0;
      if (state_q == BURST) begin
         rdreq_en   = enable && !bus.ch_empty[grant_q] &&
                      (rd_cnt_q < CNT_W'(BURST_MAX)) && credit;
         burst_done = !rdreq_en && ((rd_cnt_q == CNT_W'(BURST_MAX)) ||
                                    bus.ch_empty[grant_q] || !enable);
      end
      if (rdreq_en) bus.ch_rdreq[grant_q] = 1'b1;
   end

   // Non-showahead FIFOs: the word read in cycle t is on ch_q during t+1, tagged at issue.
   assign word_in = bus.ch_q[int'(infl_ch_q)*DATA_W +: DATA_W];

   always_comb begin
      infl_d      = rdreq_en;
      infl_ch_d   = grant_q;
      head_data_d = head_data_q;
      head_ch_d   = head_ch_q;
      tail_data_d = tail_data_q;
      tail_ch_d   = tail_ch_q;
      if (pop) begin
         head_data_d = tail_data_q;
         head_ch_d   = tail_ch_q;
      end
      if (push) begin
         if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
            head_data_d = word_in;
            head_ch_d   = infl_ch_q;
         end else begin
            tail_data_d = word_in;
            tail_ch_d   = infl_ch_q;
         end
      end
      occ_d = occ_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         infl_q      <= 1'b0;
         infl_ch_q   <= '0;
         occ_q       <= 2'd0;
         head_data_q <= '0;
         head_ch_q   <= '0;
         tail_data_q <= '0;
         tail_ch_q   <= '0;
      end else begin
         infl_q      <= infl_d;
         infl_ch_q   <= infl_ch_d;
         occ_q       <= occ_d;
         head_data_q <= head_data_d;
         head_ch_q   <= head_ch_d;
         tail_data_q <= tail_data_d;
         tail_ch_q   <= tail_ch_d;
      end
   end

   assign bus.out_valid   = (occ_q != 2'd0);
   assign bus.out_data    = head_data_q;
   assign bus.out_channel = head_ch_q;
   assign busy            = (state_q != IDLE) || infl_q || (occ_q != 2'd0);

`ifdef FIFO_DRAIN_STATS_EN
   logic [15:0] word_count_q, word_count_d;

   always_comb begin
      word_count_d = word_count_q;
      if (pop && (word_count_q != 16'hFFFF)) word_count_d = word_count_q + 16'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) word_count_q <= 16'd0;
      else          word_count_q <= word_count_d;
   end

   assign word_count = word_count_q;
`else
   assign word_count = 16'd0;
`endif
endmodule
